// File: rtl/multiply_two_inputs.sv
// Sequential signed fixed-point multiplier between FIFOs.
// Shift-add core, one bit per cycle, result dequantized by QUANT_BITS.
module multiply_two_inputs #(
   parameter int WIDTH      = 32,
   parameter int QUANT_BITS = 10
) (
   input  logic             clock,
   input  logic             reset,
   output logic             inA_rd_en,
   input  logic             inA_empty,
   input  logic [WIDTH-1:0] inA_dout,
   output logic             inB_rd_en,
   input  logic             inB_empty,
   input  logic [WIDTH-1:0] inB_dout,
   output logic             out_wr_en,
   input  logic             out_full,
   output logic [WIDTH-1:0] out_din
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_OUT
   } state_t;

   state_t               state_q, state_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [2*WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]     mplier_q, mplier_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 sign_q, sign_d;

   logic [WIDTH-1:0]     abs_a, abs_b;
   logic signed [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]     result;

   // Magnitudes as unsigned: the most negative value maps onto 2^(WIDTH-1).
   always_comb begin
      abs_a  = inA_dout[WIDTH-1] ? -inA_dout : inA_dout;
      abs_b  = inB_dout[WIDTH-1] ? -inB_dout : inB_dout;
      prod   = sign_q ? -acc_q : acc_q;
      result = WIDTH'(prod >>> QUANT_BITS);
   end

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      cnt_d     = cnt_q;
      sign_d    = sign_q;
      inA_rd_en = 1'b0;
      inB_rd_en = 1'b0;
      out_wr_en = 1'b0;
      out_din   = '0;
      unique case (state_q)
         S_IDLE: begin
            if (!inA_empty && !inB_empty) begin
               inA_rd_en = 1'b1;
               inB_rd_en = 1'b1;
               mcand_d   = {{WIDTH{1'b0}}, abs_a};
               mplier_d  = abs_b;
               sign_d    = inA_dout[WIDTH-1] ^ inB_dout[WIDTH-1];
               acc_d     = '0;
               cnt_d     = '0;
               state_d   = S_MUL;
            end
         end
         S_MUL: begin
            if (mplier_q[0]) begin
               acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               state_d = S_OUT;
            end
         end
         S_OUT: begin
            if (!out_full) begin
               out_wr_en = 1'b1;
               out_din   = result;
               state_d   = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         sign_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         sign_q   <= sign_d;
      end
   end

endmodule

// File: tb/tb_multiply_two_inputs.sv
// Bench for multiply_two_inputs: FIFO models around the DUT,
// random and directed operands checked against an arithmetic model.
module tb_multiply_two_inputs;

   localparam int W = 32;
   localparam int Q = 10;

   logic          clock = 1'b0;
   logic          reset;
   logic          inA_rd_en, inB_rd_en, out_wr_en;
   logic          inA_empty, inB_empty, out_full;
   logic [W-1:0]  inA_dout, inB_dout, out_din;

   int            checks = 0;
   int            errors = 0;
   logic [W-1:0]  qa[$];
   logic [W-1:0]  qb[$];
   logic [W-1:0]  exp_q[$];
   logic [W-1:0]  got_q[$];
   int            cyc = 0;
   int            pops = 0;
   int            pushes = 0;
   int            rd_cyc = 0;
   int            wr_cyc = 0;

   always #5 clock = ~clock;

   multiply_two_inputs #(.WIDTH(W), .QUANT_BITS(Q)) dut (
      .clock     (clock),
      .reset     (reset),
      .inA_rd_en (inA_rd_en),
      .inA_empty (inA_empty),
      .inA_dout  (inA_dout),
      .inB_rd_en (inB_rd_en),
      .inB_empty (inB_empty),
      .inB_dout  (inB_dout),
      .out_wr_en (out_wr_en),
      .out_full  (out_full),
      .out_din   (out_din)
   );

   // Floor of the true product divided by 2^Q, wrapped to W bits.
   function automatic logic [W-1:0] model(logic [W-1:0] a, logic [W-1:0] b);
      longint p;
      p = longint'($signed(a)) * longint'($signed(b));
      return W'(p >>> Q);
   endfunction

   task automatic refresh();
      inA_empty = (qa.size() == 0);
      inB_empty = (qb.size() == 0);
      inA_dout  = (qa.size() > 0) ? qa[0] : '0;
      inB_dout  = (qb.size() > 0) ? qb[0] : '0;
   endtask

   // FIFO models and output capture; pops land just after the clock edge.
   initial begin
      bit pa, pb;
      refresh();
      forever begin
         @(negedge clock);
         pa = inA_rd_en;
         pb = inB_rd_en;
         checks++;
         if (inA_rd_en !== inB_rd_en) begin
            errors++;
            $display("FAIL pop_pair: rdA=%b rdB=%b want equal", inA_rd_en, inB_rd_en);
         end
         checks++;
         if (out_wr_en !== 1'b1 && out_din !== '0) begin
            errors++;
            $display("FAIL idle_dout: out_din=%h want 0 when wr_en=%b", out_din, out_wr_en);
         end
         if (reset && pa) begin
            pops++;
            rd_cyc = cyc;
         end
         if (reset && out_wr_en === 1'b1) begin
            got_q.push_back(out_din);
            pushes++;
            wr_cyc = cyc;
         end
         @(posedge clock);
         #1;
         cyc++;
         if (reset && pa && qa.size() > 0) void'(qa.pop_front());
         if (reset && pb && qb.size() > 0) void'(qb.pop_front());
         refresh();
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic step(int n);
      repeat (n) @(posedge clock);
      #3;
   endtask

   task automatic push_pair(logic [W-1:0] a, logic [W-1:0] b);
      qa.push_back(a);
      qb.push_back(b);
      exp_q.push_back(model(a, b));
   endtask

   task automatic push_exp(logic [W-1:0] a, logic [W-1:0] b, logic [W-1:0] e);
      qa.push_back(a);
      qb.push_back(b);
      exp_q.push_back(e);
   endtask

   task automatic collect(string name, int n, int budget);
      int k = 0;
      while (got_q.size() < n && k < budget) begin
         @(posedge clock);
         k++;
      end
      checks++;
      if (got_q.size() < n) begin
         errors++;
         $display("FAIL %s_timeout: got %0d results want %0d", name, got_q.size(), n);
      end
      for (int i = 0; i < n && got_q.size() > 0; i++) begin
         logic [W-1:0] g, e;
         g = got_q.pop_front();
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
         checks++;
         if (g !== e) begin
            errors++;
            $display("FAIL %s[%0d]: got %h want %h", name, i, g, e);
         end
      end
   endtask

   task automatic test_reset();
      reset    = 1'b0;
      out_full = 1'b0;
      step(3);
      checks += 4;
      if (inA_rd_en !== 1'b0) begin
         errors++; $display("FAIL rst_rdA: got %b want 0", inA_rd_en);
      end
      if (inB_rd_en !== 1'b0) begin
         errors++; $display("FAIL rst_rdB: got %b want 0", inB_rd_en);
      end
      if (out_wr_en !== 1'b0) begin
         errors++; $display("FAIL rst_wr: got %b want 0", out_wr_en);
      end
      if (out_din !== '0) begin
         errors++; $display("FAIL rst_dout: got %h want 0", out_din);
      end
      reset = 1'b1;
      step(2);
   endtask

   task automatic test_basic();
      int p0 = pushes;
      push_exp(32'd1024, 32'd1024, 32'd1024);
      collect("basic", 1, 80);
      checks++;
      if (wr_cyc - rd_cyc != W + 1) begin
         errors++;
         $display("FAIL latency: got %0d want %0d", wr_cyc - rd_cyc, W + 1);
      end
      step(5);
      checks++;
      if (pushes - p0 != 1) begin
         errors++;
         $display("FAIL basic_pushes: got %0d want 1", pushes - p0);
      end
   endtask

   task automatic test_signs();
      push_exp(-32'sd2048, 32'd1536, 32'hFFFF_F400);
      push_exp(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);
      push_exp(32'd0, -32'sd7, 32'd0);
      push_exp(32'h8000_0000, 32'd1024, 32'h8000_0000);
      push_exp(32'h8000_0000, -32'sd1024, 32'h8000_0000);
      push_exp(32'd7, 32'd0, 32'd0);
      push_exp(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
      push_exp(32'd3000, -32'sd5, 32'hFFFF_FFF1);
      push_exp(32'h0010_0000, 32'h0010_0000, 32'h4000_0000);
      collect("signs", 9, 9 * (W + 2) + 40);
   endtask

   task automatic test_backpressure();
      int p0, c0;
      step(1);
      out_full = 1'b1;
      p0 = pushes;
      c0 = pops;
      push_pair(32'd300000, -32'sd77);
      push_pair(32'd5000, 32'd6000);
      step(W + 12);
      checks += 2;
      if (pushes != p0) begin
         errors++; $display("FAIL bp_push: got %0d pushes want 0", pushes - p0);
      end
      if (pops - c0 != 1) begin
         errors++; $display("FAIL bp_pop: got %0d pops want 1", pops - c0);
      end
      out_full = 1'b0;
      collect("bp", 2, 2 * (W + 2) + 20);
      checks++;
      if (pops - c0 != 2) begin
         errors++; $display("FAIL bp_pop2: got %0d pops want 2", pops - c0);
      end
   endtask

   task automatic test_starve();
      int c0 = pops;
      logic [W-1:0] a, b;
      a = $urandom();
      b = $urandom();
      qa.push_back(a);
      step(20);
      checks++;
      if (pops != c0) begin
         errors++; $display("FAIL starve_pop: got %0d pops want 0", pops - c0);
      end
      qb.push_back(b);
      exp_q.push_back(model(a, b));
      collect("starve", 1, W + 20);
      checks++;
      if (pops - c0 != 1) begin
         errors++; $display("FAIL starve_pop2: got %0d pops want 1", pops - c0);
      end
   endtask

   task automatic test_reset_mid();
      int c0 = pops;
      int p0 = pushes;
      int k = 0;
      push_pair(32'd123456, -32'sd98765);
      while (pops == c0 && k < 20) begin
         step(1);
         k++;
      end
      checks++;
      if (pops == c0) begin
         errors++; $display("FAIL rmid_pop: got 0 pops want 1");
      end
      step(10);
      reset = 1'b0;
      #1;
      checks += 3;
      if (out_wr_en !== 1'b0) begin
         errors++; $display("FAIL rmid_wr: got %b want 0", out_wr_en);
      end
      if (inA_rd_en !== 1'b0) begin
         errors++; $display("FAIL rmid_rd: got %b want 0", inA_rd_en);
      end
      if (out_din !== '0) begin
         errors++; $display("FAIL rmid_dout: got %h want 0", out_din);
      end
      exp_q.delete();
      step(2);
      reset = 1'b1;
      step(W + 10);
      checks++;
      if (pushes != p0) begin
         errors++; $display("FAIL rmid_push: got %0d pushes want 0", pushes - p0);
      end
      push_pair(-32'sd40000, 32'd2500);
      collect("rmid_after", 1, W + 20);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 100; i++) begin
         logic [W-1:0] v[2];
         for (int j = 0; j < 2; j++) begin
            int t;
            case ($urandom_range(0, 3))
               0: v[j] = $urandom();
               1: begin
                  t = int'($urandom_range(0, 65535)) - 32768;
                  v[j] = t;
               end
               2: v[j] = ($urandom_range(0, 1) == 1) ? 32'h8000_0000 : 32'd0;
               default: begin
                  t = int'($urandom_range(0, 2047)) - 1024;
                  v[j] = t;
               end
            endcase
         end
         push_pair(v[0], v[1]);
      end
      collect("b2b", 100, 100 * (W + 2) + 50);
      step(W + 5);
      checks++;
      if (got_q.size() != 0 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL b2b_extra: got %0d leftover want 0, exp %0d left",
                  got_q.size(), exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_signs();
      test_backpressure();
      test_starve();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
